param_tensor_core: RTL and testbench
====================================

// Module: param_tensor_core
// PURPOSE
//  Parametrised DIMxDIM signed saturating tensor core: MATMUL, ADD, RELU, MAC.
//  Operands are captured at start; one output element is produced per cycle.
//  A start/ready/done handshake replaces restart-on-start.
//  Sits between the operand register file and the result bus, as the successor of the fixed 3x3 core.
// PARAMETERS
//  DATA_WIDTH  8  signed element width (two's complement)
//  DIM         3  matrix dimension; DIM >= 2
// PORTS
//  clock_in                 in   1              single clock, rising edge
//  reset_n_in               in   1              asynchronous, active-low reset
//  start_in                 in   1              request op; accepted only when ready_out=1
//  op_select_in             in   2              00 MATMUL, 01 ADD, 10 RELU, 11 MAC
//  tensor_core_input1_in    in   DATA_WIDTH     [DIM][DIM] operand A
//  tensor_core_input2_in    in   DATA_WIDTH     [DIM][DIM] operand B
//  tensor_core_output_out   out  DATA_WIDTH     [DIM][DIM] result register C
//  ready_out                out  1              core idle, start will be accepted
//  done_out                 out  1              one-cycle pulse, C final
//  saturated_out            out  1              sticky: some element of last op clamped
// BEHAVIOUR
//  Reset (async, reset_n_in=0):
//   - state=IDLE; C=0, done_out=0, saturated_out=0, ready_out=1, index=0.
//   - Applies immediately mid-operation; the in-flight op is abandoned.
//  Accept:
//   - start_in & ready_out at edge E: capture A, B and op into operand registers.
//   - Clear saturated_out; ready_out drops after E.
//   - start_in while busy is ignored (no queueing, no restart).
//  FSM: IDLE -> RUN (MATMUL/ADD/MAC) or IDLE -> FIN (RELU); RUN -> FIN at index=DIM*DIM-1; FIN -> IDLE.
//   - RUN: index counts 0..DIM*DIM-1 row-major (row=index/DIM, col=index%DIM).
//     One C[row][col] is written per edge, at E+1 .. E+DIM*DIM.
//   - RELU: at E, each C[i][j] with sign bit 1 becomes 0; others are unchanged; A/B are unused.
//   - FIN: done_out=1 for exactly one cycle, ready_out=0; C holds. IDLE follows; ready_out=1.
//  Latency:
//   - MATMUL/ADD/MAC: done_out high in the cycle after edge E+DIM*DIM.
//   - RELU: done_out high in the cycle after E.
//  Arithmetic, per element (full precision, then saturate to [-2^(DW-1), 2^(DW-1)-1]):
//   - MATMUL: sum_k A[r][k]*B[k][c]. Accumulator width 2*DW+clog2(DIM), signed.
//   - MAC: C[r][c] + sum_k A[r][k]*B[k][c], using the C value held before this write.
//     Accumulator width 2*DW+clog2(DIM)+1.
//   - ADD: A[r][c]+B[r][c], DW+1 bits.
//   - Clamped result -> saturated_out set (sticky until next accept or reset).
//  Boundaries:
//   - Exact max/min values pass unflagged.
//   - start_in held high through FIN is accepted again at the first IDLE edge (back-to-back ops).
//   - Input ports may change freely after E.
//   - op_select_in is sampled only at accept.
// STRUCTURE
//  Package tensor_core_pkg:
//   - op_e enum (OP_MATMUL, OP_ADD, OP_RELU, OP_MAC).
//   - state_e enum (IDLE, RUN, FIN).
//   - function sat_to_width(value, DW) returning the clamped value and a clamp flag.
//  Sub-module tensor_sat_dot (combinational):
//   - DIM-wide signed dot product plus optional addend (MAC) plus saturator.
//   - Outputs the DW-bit result and a clamp bit.
//   - The top level holds the FSM, index counter, operand/result registers and the ADD path.
// TESTING  (DATA_WIDTH=8, DIM=3; E = accept edge)
//  1. MATMUL A=I, B=[[1,2,3],[4,5,6],[7,8,9]] -> C=B.
//     C[0][0] written at E+1, C[2][2] at E+9; done_out one cycle after E+9; saturated_out=0.
//  2. MATMUL A=all 127, B=all 127 -> C all 127, saturated_out=1.
//     A=all -128, B=all 127 -> C all -128, saturated_out=1.
//  3. ADD A=[100,-3,127,-128,...], B=[50,2,0,0,...] -> C=[127,-1,127,-128,...]; saturated_out=1.
//     Rerun with A=B=1 -> saturated_out cleared to 0.
//  4. RELU after test 3 -> -1 and -128 become 0; 127 is kept; done_out one cycle after E.
//  5. MATMUL I*B (C=B) then MAC I*B -> C=2*B.
//     MAC with C=100, product 100 -> 127, saturated_out=1.
//  6. Control:
//     - start_in pulsed at E+4 of a MATMUL -> ignored, C unchanged vs golden.
//     - reset_n_in low at E+5 -> C=0, ready_out=1 asynchronously, no done_out.
//     - start_in held high -> back-to-back accepts with one IDLE cycle between.

Source files
------------

// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg: shared op/state encodings and the signed saturation helper for the tensor core.
package tensor_core_pkg;
  localparam int SAT_W = 64;
  typedef enum logic [1:0] {OP_MATMUL = 2'b00, OP_ADD = 2'b01, OP_RELU = 2'b10, OP_MAC = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;
  // clamp sits in the LSB so callers can peel it off with a 1-bit cast and the value with >> 1
  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    clamp;
  } sat_t;
  function automatic sat_t sat_to_width(input logic signed [SAT_W-1:0] value, input int dw);
    logic signed [SAT_W-1:0] hi, lo;
    hi = $signed((SAT_W'(1) << (dw - 1)) - SAT_W'(1));
    lo = ~hi;
    sat_to_width.clamp = (value > hi) || (value < lo);
    sat_to_width.value = (value > hi) ? hi : (value < lo) ? lo : value;
  endfunction
endpackage

// File: rtl/tensor_sat_dot.sv
// tensor_sat_dot: DIM-wide signed dot product with optional addend, saturated to DW bits.
module tensor_sat_dot
  import tensor_core_pkg::*;
#(
  parameter int DW  = 8,
  parameter int DIM = 3
) (
  input  logic [DIM-1:0][DW-1:0] row_a,
  input  logic [DIM-1:0][DW-1:0] col_b,
  input  logic [DW-1:0]          addend,
  input  logic                   add_en,
  output logic [DW-1:0]          result,
  output logic                   clamp
);
  localparam int AW = 2 * DW + $clog2(DIM) + 1;
  logic signed [AW-1:0] acc;
  always_comb begin
    acc = add_en ? AW'($signed(addend)) : '0;
    for (int k = 0; k < DIM; k++) acc = acc + AW'($signed(row_a[k]) * $signed(col_b[k]));
  end
  assign result = DW'(sat_to_width(SAT_W'(acc), DW) >> 1);
  assign clamp  = 1'(sat_to_width(SAT_W'(acc), DW));
endmodule

// File: rtl/param_tensor_core.sv
// param_tensor_core: DIMxDIM signed saturating tensor core (MATMUL/ADD/RELU/MAC), one element per cycle.
module param_tensor_core
  import tensor_core_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 3
) (
  input  logic                                       clock_in,
  input  logic                                       reset_n_in,
  input  logic                                       start_in,
  input  logic [1:0]                                 op_select_in,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]    tensor_core_input1_in,
  input  logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]    tensor_core_input2_in,
  output logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0]    tensor_core_output_out,
  output logic                                       ready_out,
  output logic                                       done_out,
  output logic                                       saturated_out
);
  localparam int N  = DIM * DIM;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(DIM);
  typedef logic [DIM-1:0][DIM-1:0][DATA_WIDTH-1:0] mat_t;
  state_e                         state_q, state_d;
  op_e                            op_q, op_d;
  mat_t                           a_q, a_d, b_q, b_d, c_q, c_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           sat_q, sat_d;
  logic [RW-1:0]                  row, col;
  logic [DIM-1:0][DATA_WIDTH-1:0] col_b;
  logic signed [DATA_WIDTH:0]     add_sum;
  logic [DATA_WIDTH-1:0]          dot_res, add_res;
  logic                           dot_clamp, add_clamp;
  always_comb begin
    row = RW'(idx_q / DIM);
    col = RW'(idx_q % DIM);
    for (int k = 0; k < DIM; k++) col_b[k] = b_q[k][col];
    add_sum = $signed({a_q[row][col][DATA_WIDTH-1], a_q[row][col]})
            + $signed({b_q[row][col][DATA_WIDTH-1], b_q[row][col]});
  end
  assign add_res   = DATA_WIDTH'(sat_to_width(SAT_W'(add_sum), DATA_WIDTH) >> 1);
  assign add_clamp = 1'(sat_to_width(SAT_W'(add_sum), DATA_WIDTH));
  tensor_sat_dot #(.DW(DATA_WIDTH), .DIM(DIM)) u_dot (
    .row_a  (a_q[row]),
    .col_b  (col_b),
    .addend (c_q[row][col]),
    .add_en (op_q == OP_MAC),
    .result (dot_res),
    .clamp  (dot_clamp)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: if (start_in) begin
        op_d  = op_e'(op_select_in);
        a_d   = tensor_core_input1_in;
        b_d   = tensor_core_input2_in;
        sat_d = 1'b0;
        idx_d = '0;
        state_d = (op_select_in == OP_RELU) ? FIN : RUN;
        // RELU completes in the accept cycle on the held result
        if (op_select_in == OP_RELU)
          for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) c_d[i][j] = c_q[i][j][DATA_WIDTH-1] ? '0 : c_q[i][j];
      end
      RUN: begin
        c_d[row][col] = (op_q == OP_ADD) ? add_res : dot_res;
        sat_d   = sat_q | ((op_q == OP_ADD) ? add_clamp : dot_clamp);
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == IW'(N - 1)) ? FIN : RUN;
      end
      FIN: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      op_q    <= OP_MATMUL;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
    end
  end
  assign tensor_core_output_out = c_q;
  assign ready_out              = (state_q == IDLE);
  assign done_out               = (state_q == FIN);
  assign saturated_out          = sat_q;
endmodule

// File: tb/tb_param_tensor_core.sv
// tb_param_tensor_core: directed checks of param_tensor_core (DATA_WIDTH=8, DIM=3).
module tb_param_tensor_core;
  typedef logic [2:0][2:0][7:0] mat_t;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0] op_sel = 2'b00;
  mat_t       in1 = '0, in2 = '0, c;
  logic       ready, done, sat;
  int         tests = 0, failed = 0;
  int         n, cnt, rdy;
  int         v[9];
  mat_t       ident, bm, b2, t_a, t_b, t_e;

  always #5 clk = ~clk;

  param_tensor_core #(.DATA_WIDTH(8), .DIM(3)) dut (
    .clock_in               (clk),
    .reset_n_in             (rst_n),
    .start_in               (start),
    .op_select_in           (op_sel),
    .tensor_core_input1_in  (in1),
    .tensor_core_input2_in  (in2),
    .tensor_core_output_out (c),
    .ready_out              (ready),
    .done_out               (done),
    .saturated_out          (sat)
  );

  function automatic mat_t from_arr(input int a[9]);
    mat_t m;
    for (int i = 0; i < 9; i++) m[i/3][i%3] = 8'(a[i]);
    return m;
  endfunction

  function automatic mat_t fill(input int x);
    mat_t m;
    for (int i = 0; i < 9; i++) m[i/3][i%3] = 8'(x);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present an op for one edge, then scramble the inputs to prove they were captured
  task automatic issue(input logic [1:0] op, input mat_t a, input mat_t b);
    @(negedge clk);
    start = 1'b1; op_sel = op; in1 = a; in2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; op_sel = ~op; in1 = ~a; in2 = ~b;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int k = 0;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, 72'(k), 72'(exp_lat));
    @(negedge clk);
    chk({tag, " done pulse/ready"}, {done, ready}, 2'b01);
  endtask

  initial begin
    v = '{1, 0, 0, 0, 1, 0, 0, 0, 1};       ident = from_arr(v);
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9};       bm    = from_arr(v);
    v = '{2, 4, 6, 8, 10, 12, 14, 16, 18};  b2    = from_arr(v);

    #12;
    chk("reset C", c, '0);
    chk("reset ready/done/sat", {ready, done, sat}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;

    issue(2'b00, ident, bm);
    chk("t1 E C00", c[0][0], 8'd0);
    chk("t1 E ready", ready, 1'b0);
    @(negedge clk);
    chk("t1 E+1 C00", c[0][0], 8'd1);
    chk("t1 E+1 C01", c[0][1], 8'd0);
    wait_done("t1", 8);
    chk("t1 C", c, bm);
    chk("t1 sat", sat, 1'b0);

    issue(2'b00, fill(127), fill(127));
    wait_done("t2a", 9);
    chk("t2a C", c, fill(127));
    chk("t2a sat", sat, 1'b1);
    issue(2'b00, fill(-128), fill(127));
    wait_done("t2b", 9);
    chk("t2b C", c, fill(-128));
    chk("t2b sat", sat, 1'b1);

    v = '{100, -3, 127, -128, 0, 0, 0, 0, 0}; t_a = from_arr(v);
    v = '{50, 2, 0, 0, 0, 0, 0, 0, 0};        t_b = from_arr(v);
    v = '{127, -1, 127, -128, 0, 0, 0, 0, 0}; t_e = from_arr(v);
    issue(2'b01, t_a, t_b);
    wait_done("t3a", 9);
    chk("t3a C", c, t_e);
    chk("t3a sat", sat, 1'b1);
    issue(2'b01, fill(1), fill(1));
    wait_done("t3b", 9);
    chk("t3b C", c, fill(2));
    chk("t3b sat cleared", sat, 1'b0);
    v = '{100, -100, 0, 0, 0, 0, 0, 0, 0};    t_a = from_arr(v);
    v = '{27, -28, 0, 0, 0, 0, 0, 0, 0};      t_b = from_arr(v);
    v = '{127, -128, 0, 0, 0, 0, 0, 0, 0};
    issue(2'b01, t_a, t_b);
    wait_done("t3c", 9);
    chk("t3c exact bounds C", c, from_arr(v));
    chk("t3c exact bounds sat", sat, 1'b0);
    v = '{100, -3, 127, -128, 0, 0, 0, 0, 0}; t_a = from_arr(v);
    v = '{50, 2, 0, 0, 0, 0, 0, 0, 0};        t_b = from_arr(v);
    issue(2'b01, t_a, t_b);
    wait_done("t3d", 9);
    chk("t3d C", c, t_e);

    issue(2'b10, fill(-5), fill(-5));
    wait_done("t4", 0);
    v = '{127, 0, 127, 0, 0, 0, 0, 0, 0};
    chk("t4 relu C", c, from_arr(v));
    chk("t4 sat", sat, 1'b0);

    issue(2'b00, ident, bm);
    wait_done("t5a", 9);
    chk("t5a C", c, bm);
    issue(2'b11, ident, bm);
    wait_done("t5b", 9);
    chk("t5b mac C", c, b2);
    chk("t5b sat", sat, 1'b0);
    issue(2'b01, fill(50), fill(50));
    wait_done("t5c", 9);
    chk("t5c C", c, fill(100));
    issue(2'b11, ident, fill(100));
    wait_done("t5d", 9);
    chk("t5d mac sat C", c, fill(127));
    chk("t5d sat", sat, 1'b1);

    issue(2'b00, ident, bm);
    repeat (3) @(negedge clk);
    start = 1'b1; op_sel = 2'b01; in1 = fill(5); in2 = fill(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    wait_done("t6a busy start", 5);
    chk("t6a C", c, bm);

    issue(2'b00, fill(127), fill(127));
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6b async reset C", c, '0);
    chk("t6b async reset ready/sat", {ready, sat}, 2'b10);
    @(negedge clk);
    chk("t6b reset done", done, 1'b0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      cnt += int'(done);
    end
    chk("t6b no done after abandon", 72'(cnt), 72'(0));
    chk("t6b C stays 0", c, '0);

    @(negedge clk);
    start = 1'b1; op_sel = 2'b01; in1 = fill(1); in2 = fill(1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6c first done seen", 72'(n < 40), 72'(1));
    cnt = 0;
    rdy = 0;
    do begin
      @(negedge clk);
      cnt++;
      rdy += int'(ready);
    end while (!done && cnt < 40);
    chk("t6c done spacing", 72'(cnt), 72'(11));
    chk("t6c idle cycles", 72'(rdy), 72'(1));
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("t6c final ready", ready, 1'b1);
    chk("t6c final C", c, fill(2));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
